// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/DISP with ready
// handshakes, control flow, halt, illegal-opcode trap and retire counter.
module multicycle_controller #(
    parameter int unsigned INSTR_W  = 12,
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               imem_ready,
    input  logic               mem_ready,
    input  logic               disp_ready,
    input  logic               zero_flag,
    output logic               imem_re,
    output logic               IR_we,
    output logic               PC_inc,
    output logic               PC_load,
    output logic               DM_we,
    output logic               DM_re,
    output logic               RF_we,
    output logic               loadSignal,
    output logic [2:0]         ALU_op,
    output logic               disp_valid,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_DISP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_BEQZ  = 3'b101;
    localparam logic [2:0] OP_DISP  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [2:0] ALU_MEM  = 3'b001;
    localparam logic [2:0] ALU_DISP = 3'b111;

    logic [2:0]          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                illegal_q, illegal_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire_c;

    logic [OPCODE_W-1:0] opcode_c;
    logic [2:0]          op_low_c;
    logic                op_illegal_c;
    logic                unused_instr_c;

    // Opcode field; any set bit above the 3-bit opcode space is a trap.
    assign opcode_c       = instr[INSTR_W-1 -: OPCODE_W];
    assign op_low_c       = opcode_c[2:0];
    assign op_illegal_c   = (opcode_c >> 3) != '0;
    assign unused_instr_c = ^instr[INSTR_W-OPCODE_W-1:0];

    assign illegal_op  = illegal_q;
    assign retired_cnt = cnt_q;

    // State, latched opcode, sticky trap flag and saturating retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            if (retire_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode from the current state and op_q.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        retire_c   = 1'b0;
        imem_re    = 1'b0;
        IR_we      = 1'b0;
        PC_inc     = 1'b0;
        PC_load    = 1'b0;
        DM_we      = 1'b0;
        DM_re      = 1'b0;
        RF_we      = 1'b0;
        loadSignal = 1'b0;
        ALU_op     = 3'b000;
        disp_valid = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_re = 1'b1;
                if (imem_ready) begin
                    IR_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = op_low_c;
                if (op_illegal_c) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    case (op_low_c)
                        OP_ADD, OP_SUB:    state_d = S_EXEC;
                        OP_LOAD, OP_STORE: state_d = S_MEM;
                        OP_DISP:           state_d = S_DISP;
                        OP_JMP: begin
                            PC_load  = 1'b1;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_BEQZ: begin
                            PC_load  = zero_flag;
                            PC_inc   = !zero_flag;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_HALT: begin
                            retire_c = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_EXEC: begin
                ALU_op   = op_q;
                RF_we    = 1'b1;
                PC_inc   = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM: begin
                loadSignal = 1'b1;
                ALU_op     = ALU_MEM;
                if (op_q == OP_LOAD) begin
                    DM_re = 1'b1;
                end else begin
                    DM_we = 1'b1;
                end
                if (mem_ready) begin
                    RF_we    = (op_q == OP_LOAD);
                    PC_inc   = 1'b1;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DISP: begin
                disp_valid = 1'b1;
                ALU_op     = ALU_DISP;
                if (disp_ready) begin
                    PC_inc   = 1'b1;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: default instance plus a 4-bit-opcode,
// 2-bit-counter instance on shared inputs, checked against a reference model.
module tb_multicycle_controller;

    logic clk;
    logic reset, start, imem_ready, mem_ready, disp_ready, zero_flag;
    logic [11:0] instr;

    logic [1:0] o_imre, o_irwe, o_pcinc, o_pcload, o_dmwe, o_dmre;
    logic [1:0] o_rfwe, o_lsig, o_dval, o_halt, o_ill;
    logic [2:0] o_alu [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.INSTR_W(12), .OPCODE_W(3), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .imem_ready(imem_ready), .mem_ready(mem_ready), .disp_ready(disp_ready),
        .zero_flag(zero_flag), .imem_re(o_imre[0]), .IR_we(o_irwe[0]),
        .PC_inc(o_pcinc[0]), .PC_load(o_pcload[0]), .DM_we(o_dmwe[0]),
        .DM_re(o_dmre[0]), .RF_we(o_rfwe[0]), .loadSignal(o_lsig[0]),
        .ALU_op(o_alu[0]), .disp_valid(o_dval[0]), .halted(o_halt[0]),
        .illegal_op(o_ill[0]), .retired_cnt(cnt0));

    multicycle_controller #(.INSTR_W(12), .OPCODE_W(4), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .imem_ready(imem_ready), .mem_ready(mem_ready), .disp_ready(disp_ready),
        .zero_flag(zero_flag), .imem_re(o_imre[1]), .IR_we(o_irwe[1]),
        .PC_inc(o_pcinc[1]), .PC_load(o_pcload[1]), .DM_we(o_dmwe[1]),
        .DM_re(o_dmre[1]), .RF_we(o_rfwe[1]), .loadSignal(o_lsig[1]),
        .ALU_op(o_alu[1]), .disp_valid(o_dval[1]), .halted(o_halt[1]),
        .illegal_op(o_ill[1]), .retired_cnt(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions of the packed output vector.
    localparam int B_IMRE = 13, B_IRWE = 12, B_PCINC = 11, B_PCLD = 10;
    localparam int B_DMWE = 9, B_DMRE = 8, B_RFWE = 7, B_LSIG = 6;
    localparam int B_DVAL = 2, B_HALT = 1, B_ILL = 0;

    // Model phases, named after the instruction steps.
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3;
    localparam int P_MEM = 4, P_DISP = 5, P_HALT = 6;

    int ph [2];
    int mop [2];
    bit mill [2];
    int mcnt [2];
    int opw [2]  = '{3, 4};
    int cmax [2] = '{65535, 3};
    bit mvalid = 1'b0;

    function automatic logic [13:0] actv(input int k);
        return {o_imre[k], o_irwe[k], o_pcinc[k], o_pcload[k], o_dmwe[k],
                o_dmre[k], o_rfwe[k], o_lsig[k], o_alu[k], o_dval[k],
                o_halt[k], o_ill[k]};
    endfunction

    function automatic int actcnt(input int k);
        return (k == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Expected outputs for one instance this cycle, then advance the model.
    task automatic model_one(input int k);
        logic [13:0] e;
        int nph, nop, opf;
        bit ret, nill;
        e    = '0;
        nph  = ph[k];
        nop  = mop[k];
        ret  = 1'b0;
        nill = 1'b0;
        opf  = int'(instr) >> (12 - opw[k]);
        case (ph[k])
            P_IDLE: if (start) nph = P_FETCH;
            P_FETCH: begin
                e[B_IMRE] = 1'b1;
                if (imem_ready) begin
                    e[B_IRWE] = 1'b1;
                    nph = P_DECODE;
                end
            end
            P_DECODE: begin
                nop = opf & 7;
                if (opf > 7) begin
                    nill = 1'b1;
                    nph = P_HALT;
                end else begin
                    case (opf)
                        2, 3: nph = P_EXEC;
                        0, 1: nph = P_MEM;
                        6:    nph = P_DISP;
                        4: begin e[B_PCLD] = 1'b1; ret = 1'b1; nph = P_FETCH; end
                        5: begin
                            e[B_PCLD] = zero_flag;
                            e[B_PCINC] = !zero_flag;
                            ret = 1'b1;
                            nph = P_FETCH;
                        end
                        default: begin ret = 1'b1; nph = P_HALT; end
                    endcase
                end
            end
            P_EXEC: begin
                e[5:3] = 3'(mop[k]);
                e[B_RFWE] = 1'b1;
                e[B_PCINC] = 1'b1;
                ret = 1'b1;
                nph = P_FETCH;
            end
            P_MEM: begin
                e[B_LSIG] = 1'b1;
                e[5:3] = 3'b001;
                if (mop[k] == 0) e[B_DMRE] = 1'b1;
                else e[B_DMWE] = 1'b1;
                if (mem_ready) begin
                    e[B_PCINC] = 1'b1;
                    e[B_RFWE] = (mop[k] == 0);
                    ret = 1'b1;
                    nph = P_FETCH;
                end
            end
            P_DISP: begin
                e[B_DVAL] = 1'b1;
                e[5:3] = 3'b111;
                if (disp_ready) begin
                    e[B_PCINC] = 1'b1;
                    ret = 1'b1;
                    nph = P_FETCH;
                end
            end
            default: e[B_HALT] = 1'b1;
        endcase
        e[B_ILL] = mill[k];

        if (mvalid) begin
            chk($sformatf("outs%0d", k), int'(actv(k)), int'(e));
            chk($sformatf("cnt%0d", k), actcnt(k), mcnt[k]);
            chk($sformatf("pc_excl%0d", k), int'(o_pcinc[k] & o_pcload[k]), 0);
            chk($sformatf("dm_excl%0d", k), int'(o_dmwe[k] & o_dmre[k]), 0);
        end

        if (reset) begin
            ph[k] = P_IDLE; mop[k] = 0; mill[k] = 1'b0; mcnt[k] = 0;
        end else begin
            ph[k] = nph;
            mop[k] = nop;
            mill[k] = mill[k] | nill;
            if (ret && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_one(0);
        model_one(1);
        if (reset) mvalid = 1'b1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        half();
        adv();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr = '0; imem_ready = 1'b0;
        mem_ready = 1'b0; disp_ready = 1'b0; zero_flag = 1'b0;
        #1;
        cyc(); cyc();

        // add 0x600 with every ready high
        reset = 1'b0; start = 1'b1; instr = 12'h600;
        imem_ready = 1'b1; mem_ready = 1'b1; disp_ready = 1'b1;
        half(); chk("idle_outs", int'(actv(0)), 0); chk("idle_cnt", int'(cnt0), 0); adv();
        start = 1'b0;
        half(); chk("fetch_irwe", int'(o_irwe[0]), 1); chk("fetch_imre", int'(o_imre[0]), 1); adv();
        cyc();
        half();
        chk("exec_rfwe", int'(o_rfwe[0]), 1); chk("exec_alu", int'(o_alu[0]), 3);
        chk("exec_pcinc", int'(o_pcinc[0]), 1);
        adv();

        // load 0x000, mem_ready low for 4 cycles
        instr = 12'h000; mem_ready = 1'b0;
        half(); chk("cnt_after_add", int'(cnt0), 1); adv();
        cyc();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4);
            half();
            chk("ld_dmre", int'(o_dmre[0]), 1); chk("ld_lsig", int'(o_lsig[0]), 1);
            chk("ld_dmwe", int'(o_dmwe[0]), 0);
            chk("ld_rfwe", int'(o_rfwe[0]), (i == 4) ? 1 : 0);
            chk("ld_pcinc", int'(o_pcinc[0]), (i == 4) ? 1 : 0);
            adv();
        end

        // beqz taken then not taken; 0xA00 is illegal on the 4-bit instance
        instr = 12'hA00; zero_flag = 1'b1;
        cyc();
        half(); chk("beqz1_pcload", int'(o_pcload[0]), 1); chk("beqz1_pcinc", int'(o_pcinc[0]), 0); adv();
        zero_flag = 1'b0;
        cyc();
        half(); chk("beqz0_pcinc", int'(o_pcinc[0]), 1); chk("beqz0_pcload", int'(o_pcload[0]), 0); adv();
        start = 1'b1; instr = 12'hC00; disp_ready = 1'b0;
        half();
        chk("beqz_cnt", int'(cnt0), 4); chk("ill_flag", int'(o_ill[1]), 1);
        chk("ill_halt", int'(o_halt[1]), 1); chk("ill_cnt", int'(cnt1), 2);
        adv();
        start = 1'b0;
        cyc();

        // disp with disp_ready on the third cycle
        for (int i = 0; i < 3; i++) begin
            disp_ready = (i == 2);
            start = (i == 0);
            half();
            chk("disp_valid", int'(o_dval[0]), 1); chk("disp_alu", int'(o_alu[0]), 7);
            chk("disp_pcinc", int'(o_pcinc[0]), (i == 2) ? 1 : 0);
            chk("halt_hold", int'(o_halt[1]), 1);
            adv();
        end
        start = 1'b0;
        half();
        chk("post_disp_pcinc", int'(o_pcinc[0]), 0); chk("post_disp_imre", int'(o_imre[0]), 1);
        chk("disp_cnt", int'(cnt0), 5);
        adv();

        // reset releases the halted instance
        reset = 1'b1; cyc(); reset = 1'b0;
        half(); chk("rst_outs1", int'(actv(1)), 0); chk("rst_cnt1", int'(cnt1), 0); adv();

        // store interrupted by reset while mem_ready is low
        start = 1'b1; instr = 12'h200; mem_ready = 1'b0;
        cyc(); start = 1'b0; cyc(); cyc();
        half(); chk("st_dmwe", int'(o_dmwe[0]), 1); chk("st_rfwe", int'(o_rfwe[0]), 0); adv();
        reset = 1'b1; cyc(); reset = 1'b0;
        half();
        chk("st_rst_dmwe", int'(o_dmwe[0]), 0); chk("st_rst_outs", int'(actv(0)), 0);
        chk("st_rst_cnt", int'(cnt0), 0);
        adv();

        // five 3-cycle instructions: counter saturation on the 2-bit instance
        start = 1'b1; instr = 12'h300; mem_ready = 1'b1;
        cyc(); start = 1'b0;
        repeat (15) cyc();
        half(); chk("sat_cnt1", int'(cnt1), 3); chk("sat_cnt0", int'(cnt0), 5); adv();

        // randomized traffic
        repeat (3000) begin
            reset      = ($urandom_range(0, 63) == 0);
            start      = ($urandom_range(0, 3) == 0);
            instr      = 12'($urandom);
            if ($urandom_range(0, 3) != 0) instr[11] = 1'b0;
            imem_ready = ($urandom_range(0, 2) != 0);
            mem_ready  = ($urandom_range(0, 2) != 0);
            disp_ready = ($urandom_range(0, 2) != 0);
            zero_flag  = 1'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
